// File: rtl/test_finisher_pkg.sv
// rtl/test_finisher_pkg.sv - register offsets, FSM states and STATUS bit positions for test_finisher
package test_finisher_pkg;

    localparam logic [3:0] TF_TOHOST  = 4'h0;
    localparam logic [3:0] TF_TESTNUM = 4'h4;
    localparam logic [3:0] TF_CYCLES  = 4'h8;
    localparam logic [3:0] TF_STATUS  = 4'hC;

    localparam int unsigned STATUS_DONE_BIT    = 0;
    localparam int unsigned STATUS_PASS_BIT    = 1;
    localparam int unsigned STATUS_FAIL_BIT    = 2;
    localparam int unsigned STATUS_TIMEOUT_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } tf_state_e;

endpackage

// File: rtl/tf_watchdog.sv
// rtl/tf_watchdog.sv - loadable down-counter raising a one-cycle expired pulse; built only with TEST_FINISHER_TIMEOUT_EN
`ifdef TEST_FINISHER_TIMEOUT_EN
module tf_watchdog #(
    parameter int unsigned LOAD = 1_000_000
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Expiry lands on the enabled cycle that consumes the last count, so the
    // owner leaves RUN on the same edge its cycle counter reaches LOAD.
    assign expired_o = en_i && (count_q == 32'd1);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = LOAD[31:0];
        end else if (en_i && (count_q != 32'd0)) begin
            count_d = count_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= LOAD[31:0];
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/test_finisher.sv
// rtl/test_finisher.sv - bus-mapped riscv-tests result decoder; watchdog enabled by TEST_FINISHER_TIMEOUT_EN
module test_finisher
    import test_finisher_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_testnum,
    output logic [31:0] cycles
);

    tf_state_e   state_q, state_d;
    logic [30:0] fail_q, fail_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] testnum_q, testnum_d;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q, rdata_d;
    logic [31:0] status;
    logic        hit, wr, rd, tohost_wr, wd_expired;
    logic [3:0]  offset;

    assign hit       = req_valid && (req_addr[31:4] == BASE_ADDR[31:4]);
    assign wr        = hit && req_we;
    assign rd        = hit && !req_we;
    assign offset    = {req_addr[3:2], 2'b00};
    assign tohost_wr = wr && (offset == TF_TOHOST);

`ifdef TEST_FINISHER_TIMEOUT_EN
    tf_watchdog #(
        .LOAD (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_ni    (rst),
        .en_i      (state_q == ST_RUN),
        .clr_i     (state_q == ST_IDLE),
        .expired_o (wd_expired)
    );
`else
    logic unused_cfg;
    assign unused_cfg = |{TIMEOUT_CYCLES, req_addr[1:0]};
    assign wd_expired = 1'b0;
`endif

    assign done = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
    assign pass = (state_q == ST_PASS);

    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        cycles_d  = cycles_q;
        testnum_d = testnum_q;
        if (wr && (offset == TF_TESTNUM)) begin
            testnum_d = req_wdata;
        end
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                // An odd TOHOST write outranks a coincident watchdog expiry.
                if (tohost_wr && req_wdata[0]) begin
                    if (req_wdata == 32'd1) begin
                        state_d = ST_PASS;
                        fail_d  = '0;
                    end else begin
                        state_d = ST_FAIL;
                        fail_d  = req_wdata[31:1];
                    end
                end else if (wd_expired) begin
                    state_d = ST_TIMEOUT;
                    fail_d  = testnum_q[30:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        status                     = '0;
        status[STATUS_DONE_BIT]    = done;
        status[STATUS_PASS_BIT]    = (state_q == ST_PASS);
        status[STATUS_FAIL_BIT]    = (state_q == ST_FAIL);
        status[STATUS_TIMEOUT_BIT] = (state_q == ST_TIMEOUT);
    end

    always_comb begin
        rdata_d = '0;
        case (offset)
            TF_TESTNUM: rdata_d = testnum_q;
            TF_CYCLES:  rdata_d = cycles_q;
            TF_STATUS:  rdata_d = status;
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fail_q      <= '0;
            cycles_q    <= '0;
            testnum_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            fail_q      <= fail_d;
            cycles_q    <= cycles_d;
            testnum_q   <= testnum_d;
            rsp_valid_q <= rd;
            rsp_rdata_q <= rd ? rdata_d : '0;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign fail_testnum = fail_q;
    assign cycles       = cycles_q;

endmodule

// File: tb/tb_test_finisher.sv
// tb/tb_test_finisher.sv - directed scoreboard bench for test_finisher
module tb_test_finisher;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        done;
    logic        pass;
    logic [30:0] fail_testnum;
    logic [31:0] cycles;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    test_finisher #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .done         (done),
        .pass         (pass),
        .fail_testnum (fail_testnum),
        .cycles       (cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        cyc();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        cyc();
        req_valid = 1'b0;
    endtask

    // Asserts reset between clock edges and checks the asynchronous clear.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_fnum", {1'b0, fail_testnum}, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("run_cycles0", cycles, 32'd0);
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Test 1: pass after 10 idle RUN cycles
        async_reset();
        repeat (10) cyc();
        chk("idle_cycles", cycles, 32'd10);
        bus_write(BASE + 32'h0, 32'd1);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_pass", {31'd0, pass}, 32'd1);
        chk("t1_fnum", {1'b0, fail_testnum}, 32'd0);
        chk("t1_cycles", cycles, 32'd11);
        bus_read(BASE + 32'hC, 32'h3);
        chk("rsp_pulse", {31'd0, rsp_valid}, 32'd1);
        cyc();
        chk("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        bus_read(BASE + 32'h8, 32'd11);
        bus_read(BASE + 32'h0, 32'd0);
        bus_write(BASE + 32'h0, 32'd3);
        cyc();
        chk("t1_sticky_pass", {31'd0, pass}, 32'd1);
        chk("t1_sticky_fnum", {1'b0, fail_testnum}, 32'd0);
        chk("t1_frozen", cycles, 32'd11);

        // Test 2: fail with test number 7
        async_reset();
        bus_write(BASE + 32'h4, 32'd7);
        bus_read(BASE + 32'h4, 32'd7);
        bus_write(BASE + 32'h0, 32'h0F);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_pass", {31'd0, pass}, 32'd0);
        chk("t2_fnum", {1'b0, fail_testnum}, 32'd7);
        bus_read(BASE + 32'hC, 32'h5);
        cyc();

        // Test 3: even write ignored, read-only write dropped, miss ignored
        async_reset();
        bus_write(BASE + 32'h0, 32'd2);
        chk("t3_even_done", {31'd0, done}, 32'd0);
        chk("t3_cycles1", cycles, 32'd1);
        bus_write(BASE + 32'h8, 32'hDEAD_BEEF);
        chk("t3_ro_cycles", cycles, 32'd2);
        bus_read(BASE + 32'h10, 32'd0);
        void'(exp_q.pop_back());
        cyc();
        bus_write(BASE + 32'h0, 32'd1);
        chk("t3_pass", {31'd0, pass}, 32'd1);
        chk("t3_cycles", cycles, 32'd5);

        // Test 4: watchdog
        async_reset();
        bus_write(BASE + 32'h4, 32'd4);
`ifdef TEST_FINISHER_TIMEOUT_EN
        for (int i = 0; i < 100 && !done; i++) cyc();
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_cycles", cycles, 32'd50);
        chk("t4_fnum", {1'b0, fail_testnum}, 32'd4);
        chk("t4_pass", {31'd0, pass}, 32'd0);
        bus_read(BASE + 32'hC, 32'h9);
`else
        repeat (60) cyc();
        chk("t4_no_timeout", {31'd0, done}, 32'd0);
        chk("t4_cycles", cycles, 32'd61);
        bus_read(BASE + 32'hC, 32'h0);
`endif
        cyc();
        cyc();
        chk("rsp_missing", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
